disp_source_ctrl: RTL
=====================

# disp_source_ctrl

Display source scheduler for the 4-digit multiplexed 7-segment driver of the clock design. It arbitrates between three 16-bit BCD sources (running time, alarm setting, stopwatch) and presents one registered 16-bit word to the segment scanner. It also generates the scanner's digit-rate enable and blinks the digit under edit. It sits between the timekeeping/alarm/stopwatch blocks and the dynamic segment driver.

## Interface

- SCAN_DIV, 50000, clk cycles per scan_tick (≥2)
- BLINK_TICKS, 250, scan ticks per blink half-period (≥1)
- HOLD_TICKS, 2000, scan ticks a released non-time source stays shown (≥1)
- BLANK_CODE, 4'hF, nibble substituted for a blanked digit
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- time_bcd  in  16  current time, 4 BCD digits, [15:12] leftmost
- alarm_bcd  in  16  alarm setting
- sw_bcd  in  16  stopwatch value
- req_alarm  in  1  level request to show alarm
- req_sw  in  1  level request to show stopwatch
- edit_en  in  1  edit mode active, blink selected digit
- edit_digit  in  2  digit to blink; 0 = [15:12] … 3 = [3:0]
- scan_tick  out  1  one-cycle digit-advance enable to scanner
- disp_data  out  16  registered BCD word to scanner
- src  out  2  shown source: 00 time, 01 alarm, 10 stopwatch
- grant_alarm  out  1  high while src = 01
- grant_sw  out  1  high while src = 10

## Operation

- Reset (async, reset=0): all outputs 0; state S_TIME; all counters 0; blink_phase 0.
- Prescaler: counter 0..SCAN_DIV-1; scan_tick=1 for the cycle the counter equals SCAN_DIV-1; wraps to 0.
- FSM states S_TIME, S_ALARM, S_SW; src and grants decode the state register.
  - S_TIME: req_sw → S_SW; else req_alarm → S_ALARM. Both high: S_SW wins.
  - S_ALARM: req_sw → S_SW (preempt). Otherwise hold logic.
  - S_SW: req_alarm ignored. Otherwise hold logic.
  - Hold logic: while own request high, hold_cnt = 0. While low, hold_cnt increments on each scan_tick. On the scan_tick that makes hold_cnt = HOLD_TICKS, go to S_TIME. Request reasserted mid-hold clears hold_cnt and the state stays.
- Data mux: disp_data <= source selected by the current state, every cycle.
- Blink: while edit_en=1, blink_phase toggles after every BLINK_TICKS scan ticks.
  - While edit_en=0, blink_phase and its counter are held at 0.
  - If edit_en=1 and blink_phase=1, nibble edit_digit of the muxed word is replaced by BLANK_CODE before registering. Other nibbles pass through.
- Widths: counters sized by $clog2 of their parameter; no truncation at the maximum parameter values.

## Timing

- Request → src/grant change: 1 clk after the edge sampling req.
- Request → disp_data shows new source: 2 clk.
- Source data change → disp_data: 1 clk.
- First scan_tick: SCAN_DIV cycles after reset deasserts. Period exactly SCAN_DIV.
- Return to time: same edge as the HOLD_TICKS-th scan_tick counted after request drop. disp_data shows time 1 clk later.
- edit_en falling: digit is restored within 1 clk (no partial blink).
- reset asserted mid-hold or mid-blink: immediate return to reset values. No state retained.

## Configuration

- DISP_BLINK_EN defined: blink logic as above.
- Not defined: blink counter/phase absent; edit_en and edit_digit ignored; disp_data is always the unmodified source.

## Test plan

Parameters for all scenarios: SCAN_DIV=4, BLINK_TICKS=2, HOLD_TICKS=3, DISP_BLINK_EN defined.

- Reset then idle 12 clk, time_bcd=16'h1234 → disp_data=16'h1234 from 1 clk after release; scan_tick pulses at cycles 4, 8, 12; src=00.
- req_alarm=1 with alarm_bcd=16'h0730 → grant_alarm=1 after 1 clk, disp_data=16'h0730 after 2 clk. Drop req → src=00 at the 3rd subsequent scan_tick.
- req_alarm and req_sw rise together → src=10, grant_alarm never asserts. In S_ALARM, a req_sw pulse preempts to S_SW.
- Drop req_sw, reassert after 2 scan ticks, drop again → hold restarts; return to time only 3 ticks after the second drop.
- edit_en=1, edit_digit=2, data 16'h1234 → disp_data alternates 16'h1234 / 16'h12F4 every 2 scan ticks. edit_en=0 during the blank phase → 16'h1234 next clk.
- Assert reset while in S_SW with hold_cnt=2 → all outputs 0 asynchronously; after release, state S_TIME.

Source files
------------

// File: rtl/disp_source_ctrl.sv
// disp_source_ctrl: arbitrates time/alarm/stopwatch onto the 7-segment word, scan prescaler, edit blink
// Define DISP_BLINK_EN to blank the digit under edit on alternate blink phases.
module disp_source_ctrl #(
   parameter int unsigned SCAN_DIV    = 50000,
   parameter int unsigned BLINK_TICKS = 250,
   parameter int unsigned HOLD_TICKS  = 2000,
   parameter logic [3:0]  BLANK_CODE  = 4'hF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] time_bcd,
   input  logic [15:0] alarm_bcd,
   input  logic [15:0] sw_bcd,
   input  logic        req_alarm,
   input  logic        req_sw,
   input  logic        edit_en,
   input  logic [1:0]  edit_digit,
   output logic        scan_tick,
   output logic [15:0] disp_data,
   output logic [1:0]  src,
   output logic        grant_alarm,
   output logic        grant_sw
);
   localparam logic [1:0] S_TIME  = 2'b00;
   localparam logic [1:0] S_ALARM = 2'b01;
   localparam logic [1:0] S_SW    = 2'b10;
   localparam int PW = $clog2(SCAN_DIV);
   localparam int HW = $clog2(HOLD_TICKS + 1);
   logic [PW-1:0] pre_cnt;
   logic [HW-1:0] hold_cnt, hold_nx;
   logic [1:0]    state, state_nx;
   logic          own_req;
   logic [15:0]   mux_data, out_data;

   assign scan_tick   = pre_cnt == PW'(SCAN_DIV - 1);
   assign src         = state;
   assign grant_alarm = state == S_ALARM;
   assign grant_sw    = state == S_SW;
   assign own_req     = state == S_SW ? req_sw : req_alarm;
   assign mux_data    = state == S_ALARM ? alarm_bcd : state == S_SW ? sw_bcd : time_bcd;

   always_ff @(posedge clk or negedge reset)
      if (!reset) pre_cnt <= '0;
      else pre_cnt <= scan_tick ? '0 : pre_cnt + 1'b1;

   // hold_cnt counts scan ticks since the shown source's request dropped
   always_comb begin
      state_nx = state;
      hold_nx  = '0;
      if (state == S_ALARM && req_sw) state_nx = S_SW;
      else if (state != S_ALARM && state != S_SW) state_nx = req_sw ? S_SW : req_alarm ? S_ALARM : S_TIME;
      else if (!own_req && scan_tick) begin
         if (hold_cnt == HW'(HOLD_TICKS - 1)) state_nx = S_TIME;
         else hold_nx = hold_cnt + 1'b1;
      end
      else if (!own_req) hold_nx = hold_cnt;
   end

`ifdef DISP_BLINK_EN
   localparam int BW = $clog2(BLINK_TICKS + 1);
   logic [BW-1:0] blink_cnt;
   logic          blink_phase;
   logic          blink_wrap;

   assign blink_wrap = blink_cnt == BW'(BLINK_TICKS - 1);

   always_ff @(posedge clk or negedge reset)
      if (!reset || !edit_en) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end
      else if (scan_tick) begin
         blink_cnt   <= blink_wrap ? '0 : blink_cnt + 1'b1;
         blink_phase <= blink_phase ^ blink_wrap;
      end

   // digit 0 is the leftmost nibble, so the bit offset is (3 - edit_digit) * 4
   always_comb begin
      out_data = mux_data;
      if (edit_en && blink_phase) out_data[{~edit_digit, 2'b00} +: 4] = BLANK_CODE;
   end
`else
   logic unused_edit;
   assign unused_edit = ^{edit_en, edit_digit};
   assign out_data    = mux_data;
`endif

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state     <= S_TIME;
         hold_cnt  <= '0;
         disp_data <= '0;
      end
      else begin
         state     <= state_nx;
         hold_cnt  <= hold_nx;
         disp_data <= out_data;
      end
endmodule
